// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential restoring divider.
//   state_e        : controller state encoding (IDLE / BUSY / DONE)
//   XLEN_DEFAULT   : default operand/result width
//   DIV0_QUO_FILL  : fill bit replicated across the quotient on divide-by-zero
package seq_div_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  // Divide-by-zero quotient is every bit set, for any XLEN.
  localparam logic DIV0_QUO_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: request/result bundle between a requester and the divider.
//   L, is_signed, dividend, divisor : request, sampled by the divider with L
//   quotient, remainder, busy, done : registered results and status
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            L;
  logic            is_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            busy;
  logic            done;

  modport master (
    output L, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done
  );

  modport slave (
    input  L, is_signed, dividend, divisor,
    output quotient, remainder, busy, done
  );

endinterface

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division iteration.
//   rem_i / quo_i : partial remainder and quotient/dividend shift register
//   dvs_i         : divisor magnitude
//   rem_c_o       : partial remainder after shift and trial subtract
//   quo_c_o       : shift register after shift, LSB = quotient bit
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_c_o,
  output logic [XLEN-1:0] quo_c_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // One extra bit holds the bit shifted out of rem so the trial subtract
  // cannot wrap; diff MSB set means the subtract went negative (restore).
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, dvs_i};
    quo_c_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    rem_c_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, one quotient bit per clock.
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset, priority over L
//   bus  : seq_div_if slave (L/is_signed/dividend/divisor in,
//          quotient/remainder/busy/done out, all outputs registered)
// Latency: load edge plus XLEN step edges; divide-by-zero finishes on the
// load edge. Signed operation is compiled in only when SEQ_DIV_SIGNED_EN
// is defined; otherwise is_signed is ignored.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic      Clk,
  input  logic      Rst,
  seq_div_if.slave  bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_quo_q, res_quo_d;
  logic [XLEN-1:0] res_rem_q, res_rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] fin_quo, fin_rem;
`ifdef SEQ_DIV_SIGNED_EN
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            dvd_neg, dvs_neg;
`endif

  seq_div_step #(.XLEN(XLEN)) u_step (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .dvs_i   (dvs_q),
    .rem_c_o (step_rem),
    .quo_c_o (step_quo)
  );

  // Next-state, datapath and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    fin_quo   = step_quo;
    fin_rem   = step_rem;
`ifdef SEQ_DIV_SIGNED_EN
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dvd_neg   = bus.is_signed & bus.dividend[XLEN-1];
    dvs_neg   = bus.is_signed & bus.divisor[XLEN-1];
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.L) begin
          rem_d = '0;
          cnt_d = '0;
`ifdef SEQ_DIV_SIGNED_EN
          quo_d   = dvd_neg ? XLEN'(-bus.dividend) : bus.dividend;
          dvs_d   = dvs_neg ? XLEN'(-bus.divisor) : bus.divisor;
          neg_q_d = dvd_neg ^ dvs_neg;
          neg_r_d = dvd_neg;
`else
          quo_d = bus.dividend;
          dvs_d = bus.divisor;
`endif
          // Divide-by-zero bypasses iteration and publishes immediately.
          if (bus.divisor == '0) begin
            state_d   = ST_DONE;
            res_quo_d = {XLEN{DIV0_QUO_FILL}};
            res_rem_d = bus.dividend;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
`ifdef SEQ_DIV_SIGNED_EN
        if (neg_q_q) fin_quo = XLEN'(-step_quo);
        if (neg_r_q) fin_rem = XLEN'(-step_rem);
`endif
        // Sign correction folds into the final step's result register.
        if (cnt_q == LAST_STEP) begin
          state_d   = ST_DONE;
          res_quo_d = fin_quo;
          res_rem_d = fin_rem;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
`endif
    end
  end

  assign bus.quotient  = res_quo_q;
  assign bus.remainder = res_rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div (XLEN = 64). Directed cases
// plus randomized operands checked against an arithmetic reference model.
// Signed cases are exercised when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_div_if #(.XLEN(XLEN)) bus ();

  seq_div #(.XLEN(XLEN)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic from the divider's contract.
  task automatic ref_div(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r);
    logic signed [63:0] sa, sb;
    logic use_signed;
    sa = a;
    sb = b;
`ifdef SEQ_DIV_SIGNED_EN
    use_signed = sgn;
`else
    use_signed = 1'b0;
    if (sgn) use_signed = 1'b0;
`endif
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (use_signed) begin
      if (a == MIN64 && b == ONES) begin
        q = MIN64;
        r = 64'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one division, optionally pulsing L with junk operands mid-run,
  // then check latency, busy duration and results.
  task automatic run_div(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                         input int glitch_at, input string tag);
    logic [63:0] eq, er;
    int edges, busy_n, exp_edges, exp_busy;
    ref_div(sgn, a, b, eq, er);
    exp_edges = (b == 64'd0) ? 1 : XLEN + 1;
    exp_busy  = (b == 64'd0) ? 0 : XLEN;
    @(negedge clk);
    bus.L         = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.L  = 1'b0;
    edges  = 1;
    busy_n = 0;
    while (!bus.done && edges < 200) begin
      if (bus.busy) busy_n++;
      if (edges == glitch_at) begin
        bus.L         = 1'b1;
        bus.is_signed = ~sgn;
        bus.dividend  = {$urandom, $urandom};
        bus.divisor   = {$urandom, $urandom} | 64'd1;
      end else begin
        bus.L = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    bus.L = 1'b0;
    check({tag, ".latency"}, 64'(edges), 64'(exp_edges));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, ".busy_low"}, {63'd0, bus.busy}, 64'd0);
    check({tag, ".quotient"}, bus.quotient, eq);
    check({tag, ".remainder"}, bus.remainder, er);
  endtask

  initial begin
    logic [63:0] a, b;
    int sh;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.L         = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", {63'd0, bus.busy}, 64'd0);
    check("reset.done", {63'd0, bus.done}, 64'd0);
    check("reset.quotient", bus.quotient, 64'd0);
    check("reset.remainder", bus.remainder, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned division and result hold in DONE.
    run_div(1'b0, 64'd120, 64'd29, 0, "u120_29");
    @(posedge clk);
    #1;
    check("hold.done", {63'd0, bus.done}, 64'd1);
    check("hold.quotient", bus.quotient, 64'd4);
    check("hold.remainder", bus.remainder, 64'd4);

    // Back-to-back restarts straight from DONE.
    run_div(1'b0, 64'd120, 64'd28, 0, "b2b_a");
    run_div(1'b0, 64'd84, 64'd30, 0, "b2b_b");

    // Divide by zero, then restart from that DONE.
    run_div(1'b0, 64'd30, 64'd0, 0, "div0");
    run_div(1'b0, 64'd5, 64'd7, 0, "small_dvd");
    run_div(1'b0, ONES, 64'd1, 0, "max_by_1");
    run_div(1'b0, ONES, ONES, 0, "max_by_max");
    run_div(1'b0, MIN64, ONES, 0, "min_by_ones_u");

    // L pulsed mid-division is ignored.
    run_div(1'b0, 64'd120, 64'd29, 10, "l_in_busy");

`ifdef SEQ_DIV_SIGNED_EN
    run_div(1'b1, -64'd120, 64'd29, 0, "s_neg_dvd");
    run_div(1'b1, 64'd120, -64'd29, 0, "s_neg_dvs");
    run_div(1'b1, MIN64, ONES, 0, "s_min_by_m1");
    run_div(1'b1, -64'd7, 64'd0, 0, "s_div0");
`endif

    // Reset mid-division, with L held to confirm reset priority.
    @(negedge clk);
    bus.L         = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 64'd120;
    bus.divisor   = 64'd29;
    @(posedge clk);
    #1;
    bus.L = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    bus.L        = 1'b1;
    bus.dividend = 64'd7;
    bus.divisor  = 64'd3;
    @(posedge clk);
    #1;
    check("abort.busy", {63'd0, bus.busy}, 64'd0);
    check("abort.done", {63'd0, bus.done}, 64'd0);
    check("abort.quotient", bus.quotient, 64'd0);
    check("abort.remainder", bus.remainder, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    bus.L = 1'b0;
    @(posedge clk);
    #1;
    check("abort.idle_busy", {63'd0, bus.busy}, 64'd0);
    check("abort.idle_done", {63'd0, bus.done}, 64'd0);
    run_div(1'b0, 64'd30, 64'd29, 0, "after_abort");

    // Randomized operands with varied divisor magnitude.
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      sh = $urandom_range(0, 63);
      b  = {$urandom, $urandom} >> sh;
      if (i % 4 == 3) a = b * 64'($urandom_range(0, 5)) + 64'($urandom_range(0, 3));
      if (i % 13 == 7) b = 64'd0;
      run_div(1'($urandom_range(0, 1)), a, b, (i % 5 == 0) ? $urandom_range(2, 60) : 0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
